// File: rtl/voice_scheduler_pkg.sv
// Shared types and default dimensions for the voice scheduler and its allocator.
package voice_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DRAIN = 2'd2,
      ST_MIX   = 2'd3
   } state_t;

   localparam int unsigned DEF_NUM_VOICES    = 8;
   localparam int unsigned DEF_LUT_ADDR_BITS = 12;
   localparam int unsigned DEF_SAMPLE_WIDTH  = 11;
   localparam int unsigned DEF_LUT_LATENCY   = 2;
   localparam int unsigned NOTE_ID_W         = 7;
   localparam int unsigned PHASE_W           = 32;

endpackage

// File: rtl/voice_allocator.sv
// Picks the voice for a note-on: active voice with the same id, else lowest free voice,
// else the voice under the steal pointer.
module voice_allocator
   import voice_scheduler_pkg::*;
#(
   parameter int unsigned NUM_VOICES = DEF_NUM_VOICES,
   localparam int unsigned VIDX_W    = $clog2(NUM_VOICES)
) (
   input  logic [NUM_VOICES-1:0]                i_active,
   input  logic [NUM_VOICES-1:0][NOTE_ID_W-1:0] i_ids,
   input  logic [NOTE_ID_W-1:0]                 i_note_id,
   input  logic [VIDX_W-1:0]                    i_steal_ptr,
   output logic [VIDX_W-1:0]                    o_sel,
   output logic                                 o_steal
);

   logic              w_match_hit;
   logic [VIDX_W-1:0] w_match_idx;
   logic              w_free_hit;
   logic [VIDX_W-1:0] w_free_idx;

   always_comb begin
      w_match_hit = 1'b0;
      w_match_idx = '0;
      w_free_hit  = 1'b0;
      w_free_idx  = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         if (!w_match_hit && i_active[i] && (i_ids[i] == i_note_id)) begin
            w_match_hit = 1'b1;
            w_match_idx = VIDX_W'(i);
         end
         if (!w_free_hit && !i_active[i]) begin
            w_free_hit = 1'b1;
            w_free_idx = VIDX_W'(i);
         end
      end
   end

   always_comb begin
      o_steal = 1'b0;
      if (w_match_hit) begin
         o_sel = w_match_idx;
      end else if (w_free_hit) begin
         o_sel = w_free_idx;
      end else begin
         o_sel   = i_steal_ptr;
         o_steal = 1'b1;
      end
   end

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: one sine LUT shared across voices in a per-frame sweep,
// summed into an accumulator and scaled down by the voice count.
module voice_scheduler
   import voice_scheduler_pkg::*;
#(
   parameter int unsigned NUM_VOICES    = DEF_NUM_VOICES,
   parameter int unsigned LUT_ADDR_BITS = DEF_LUT_ADDR_BITS,
   parameter int unsigned SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
   parameter int unsigned LUT_LATENCY   = DEF_LUT_LATENCY
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           sample_tick_in,
   input  logic                           note_on_valid_in,
   output logic                           note_on_ready_out,
   input  logic [NOTE_ID_W-1:0]           note_id_in,
   input  logic [PHASE_W-1:0]             note_incr_in,
   input  logic                           note_off_valid_in,
   input  logic [NOTE_ID_W-1:0]           note_off_id_in,
   output logic [LUT_ADDR_BITS-1:0]       lut_addr_out,
   input  logic signed [SAMPLE_WIDTH-1:0] lut_data_in,
   output logic signed [SAMPLE_WIDTH-1:0] audio_out,
   output logic                           audio_valid_out,
   output logic [NUM_VOICES-1:0]          active_voices_out,
   output logic                           overrun_out
);

   localparam int unsigned VIDX_W     = $clog2(NUM_VOICES);
   localparam int unsigned ACC_W      = SAMPLE_WIDTH + VIDX_W;
   localparam int unsigned MAXV       = (NUM_VOICES > LUT_LATENCY) ? NUM_VOICES : LUT_LATENCY;
   localparam int unsigned CNT_W      = $clog2(MAXV);
   localparam int unsigned DRAIN_LAST = (LUT_LATENCY > 0) ? LUT_LATENCY - 1 : 0;

   state_t                                r_state;
   state_t                                w_state_nxt;
   logic [CNT_W-1:0]                      r_cnt;
   logic [CNT_W-1:0]                      w_cnt_nxt;
   logic                                  w_ready;
   logic                                  w_sweep;
   logic                                  w_mix_enter;

   logic [NUM_VOICES-1:0]                 r_active;
   logic [NUM_VOICES-1:0][NOTE_ID_W-1:0]  r_id;
   logic [NUM_VOICES-1:0][PHASE_W-1:0]    r_incr;
   logic [NUM_VOICES-1:0][PHASE_W-1:0]    r_phase;
   logic [VIDX_W-1:0]                     r_steal_ptr;

   logic signed [ACC_W-1:0]               r_acc;
   logic signed [ACC_W-1:0]               w_contrib;
   logic signed [ACC_W-1:0]               w_acc_sum;
   logic signed [SAMPLE_WIDTH-1:0]        r_audio;
   logic                                  r_valid;
   logic                                  r_overrun;

   logic [VIDX_W-1:0]                     w_vidx;
   logic                                  w_issue;
   logic                                  w_take;
   logic                                  w_on_fire;
   logic                                  w_off_fire;
   logic [NUM_VOICES-1:0]                 w_off_mask;
   logic [NUM_VOICES-1:0]                 w_active_post;
   logic [NUM_VOICES-1:0]                 w_active_nxt;
   logic [VIDX_W-1:0]                     w_sel;
   logic                                  w_steal;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ready     = 1'b0;
      w_sweep     = 1'b0;
      w_mix_enter = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (sample_tick_in) begin
               w_state_nxt = ST_SWEEP;
               w_cnt_nxt   = '0;
            end
         end
         ST_SWEEP: begin
            w_sweep = 1'b1;
            if (r_cnt == CNT_W'(NUM_VOICES - 1)) begin
               w_cnt_nxt = '0;
               if (LUT_LATENCY == 0) begin
                  w_state_nxt = ST_MIX;
                  w_mix_enter = 1'b1;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (r_cnt == CNT_W'(DRAIN_LAST)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_MIX;
               w_mix_enter = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_MIX: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_vidx  = r_cnt[VIDX_W-1:0];
   assign w_issue = w_sweep & r_active[w_vidx];

   assign lut_addr_out = w_sweep ? r_phase[w_vidx][PHASE_W-1 -: LUT_ADDR_BITS] : '0;

   // Active-at-issue flags travel alongside the LUT read so late data can be masked.
   generate
      if (LUT_LATENCY == 0) begin : g_nolat
         assign w_take = w_issue;
      end else begin : g_lat
         logic [LUT_LATENCY-1:0] r_pipe;
         always_ff @(posedge clk_in) begin
            if (rst_in) begin
               r_pipe <= '0;
            end else begin
               r_pipe[0] <= w_issue;
               for (int unsigned i = 1; i < LUT_LATENCY; i++) begin
                  r_pipe[i] <= r_pipe[i-1];
               end
            end
         end
         assign w_take = r_pipe[LUT_LATENCY-1];
      end
   endgenerate

   assign w_contrib = w_take ? {{VIDX_W{lut_data_in[SAMPLE_WIDTH-1]}}, lut_data_in} : '0;
   assign w_acc_sum = r_acc + w_contrib;

   // The last LUT word lands on the edge entering MIX, so the output is taken from the
   // running sum at that edge and is visible throughout the MIX cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_acc     <= '0;
         r_audio   <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_valid <= w_mix_enter;
         if (r_state == ST_MIX) begin
            r_acc <= '0;
         end else begin
            r_acc <= w_acc_sum;
         end
         if (w_mix_enter) begin
            r_audio <= SAMPLE_WIDTH'(w_acc_sum >>> VIDX_W);
         end
         if (sample_tick_in && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign w_on_fire  = w_ready & note_on_valid_in;
   assign w_off_fire = w_ready & note_off_valid_in;

   always_comb begin
      w_off_mask = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         w_off_mask[i] = w_off_fire && (r_id[i] == note_off_id_in);
      end
   end

   assign w_active_post = r_active & ~w_off_mask;

   voice_allocator #(
      .NUM_VOICES (NUM_VOICES)
   ) u_alloc (
      .i_active    (w_active_post),
      .i_ids       (r_id),
      .i_note_id   (note_id_in),
      .i_steal_ptr (r_steal_ptr),
      .o_sel       (w_sel),
      .o_steal     (w_steal)
   );

   always_comb begin
      w_active_nxt = w_active_post;
      if (w_on_fire) begin
         w_active_nxt[w_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_active    <= '0;
         r_id        <= '0;
         r_incr      <= '0;
         r_phase     <= '0;
         r_steal_ptr <= '0;
      end else begin
         r_active <= w_active_nxt;
         if (w_issue) begin
            r_phase[w_vidx] <= r_phase[w_vidx] + r_incr[w_vidx];
         end
         if (w_on_fire) begin
            r_id[w_sel]    <= note_id_in;
            r_incr[w_sel]  <= note_incr_in;
            r_phase[w_sel] <= '0;
            if (w_steal) begin
               r_steal_ptr <= r_steal_ptr + VIDX_W'(1);
            end
         end
      end
   end

   assign note_on_ready_out = w_ready;
   assign audio_out         = r_audio;
   assign audio_valid_out   = r_valid;
   assign active_voices_out = r_active;
   assign overrun_out       = r_overrun;

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: external sine LUT model plus a voice-level reference model.
module tb_voice_scheduler;

   localparam int NV = 8;
   localparam int AB = 12;
   localparam int SW = 11;
   localparam int LL = 2;

   logic                 clk_in = 1'b0;
   logic                 rst_in;
   logic                 sample_tick_in;
   logic                 note_on_valid_in;
   logic                 note_on_ready_out;
   logic [6:0]           note_id_in;
   logic [31:0]          note_incr_in;
   logic                 note_off_valid_in;
   logic [6:0]           note_off_id_in;
   logic [AB-1:0]        lut_addr_out;
   logic signed [SW-1:0] lut_data_in;
   logic signed [SW-1:0] audio_out;
   logic                 audio_valid_out;
   logic [NV-1:0]        active_voices_out;
   logic                 overrun_out;

   int n_tests = 0;
   int n_fail  = 0;
   int lut_mode = 0;

   voice_scheduler #(
      .NUM_VOICES    (NV),
      .LUT_ADDR_BITS (AB),
      .SAMPLE_WIDTH  (SW),
      .LUT_LATENCY   (LL)
   ) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .sample_tick_in    (sample_tick_in),
      .note_on_valid_in  (note_on_valid_in),
      .note_on_ready_out (note_on_ready_out),
      .note_id_in        (note_id_in),
      .note_incr_in      (note_incr_in),
      .note_off_valid_in (note_off_valid_in),
      .note_off_id_in    (note_off_id_in),
      .lut_addr_out      (lut_addr_out),
      .lut_data_in       (lut_data_in),
      .audio_out         (audio_out),
      .audio_valid_out   (audio_valid_out),
      .active_voices_out (active_voices_out),
      .overrun_out       (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic signed [SW-1:0] lut_val(input logic [AB-1:0] a);
      real r;
      if (lut_mode == 1) return 11'sd1023;
      if (lut_mode == 2) return -11'sd1024;
      r = 1023.0 * $sin(6.283185307179586 * real'(a) / 4096.0);
      return SW'($rtoi(r));
   endfunction

   logic signed [SW-1:0] lut_p1, lut_p2;
   always @(posedge clk_in) begin
      lut_p1 <= lut_val(lut_addr_out);
      lut_p2 <= lut_p1;
   end
   assign lut_data_in = lut_p2;

   // Reference model: voices as plain arrays, one frame computed as a sum.
   bit          m_active[NV];
   logic [6:0]  m_id[NV];
   logic [31:0] m_incr[NV];
   logic [31:0] m_phase[NV];
   int          m_steal;
   int          m_addr[NV];

   task automatic m_reset();
      for (int i = 0; i < NV; i++) begin
         m_active[i] = 0; m_id[i] = 0; m_incr[i] = 0; m_phase[i] = 0;
      end
      m_steal = 0;
   endtask

   task automatic m_note_off(input logic [6:0] id);
      for (int i = 0; i < NV; i++) if (m_id[i] == id) m_active[i] = 0;
   endtask

   task automatic m_note_on(input logic [6:0] id, input logic [31:0] incr);
      int sel = -1;
      for (int i = 0; i < NV; i++) if (sel < 0 && m_active[i] && m_id[i] == id) sel = i;
      for (int i = 0; i < NV; i++) if (sel < 0 && !m_active[i]) sel = i;
      if (sel < 0) begin
         sel = m_steal;
         m_steal = (m_steal + 1) % NV;
      end
      m_active[sel] = 1; m_id[sel] = id; m_incr[sel] = incr; m_phase[sel] = 0;
   endtask

   function automatic logic [NV-1:0] m_bitmap();
      logic [NV-1:0] b = '0;
      for (int i = 0; i < NV; i++) b[i] = m_active[i];
      return b;
   endfunction

   task automatic m_frame(output int exp_audio);
      int sum = 0;
      for (int i = 0; i < NV; i++) begin
         m_addr[i] = m_phase[i][31:20];
         if (m_active[i]) begin
            sum += lut_val(m_phase[i][31:20]);
            m_phase[i] += m_incr[i];
         end
      end
      exp_audio = sum >>> 3;
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      step();
      step();
      rst_in = 1'b0;
      m_reset();
   endtask

   task automatic drive_cycle(input bit tick, input bit on_v, input logic [6:0] on_id,
                              input logic [31:0] on_incr, input bit off_v, input logic [6:0] off_id);
      sample_tick_in    = tick;
      note_on_valid_in  = on_v;
      note_id_in        = on_id;
      note_incr_in      = on_incr;
      note_off_valid_in = off_v;
      note_off_id_in    = off_id;
      step();
      sample_tick_in    = 1'b0;
      note_on_valid_in  = 1'b0;
      note_off_valid_in = 1'b0;
   endtask

   int obs_addr[25];
   bit obs_ready[25];
   int f_lat, f_pulses, f_audio;

   // Watches a fixed window after a tick; c counts cycles after the tick cycle.
   task automatic collect_frame(input int extra_tick_at);
      f_lat = -1; f_pulses = 0; f_audio = 0;
      for (int c = 1; c <= 24; c++) begin
         sample_tick_in = (c == extra_tick_at);
         obs_addr[c]  = lut_addr_out;
         obs_ready[c] = note_on_ready_out;
         if (audio_valid_out) begin
            f_pulses++;
            if (f_lat < 0) begin
               f_lat = c;
               f_audio = audio_out;
            end
         end
         step();
      end
      sample_tick_in = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (audio_out !== 0) begin n_fail++; $display("FAIL reset_audio: got %0d expected 0", audio_out); end
      n_tests++; if (audio_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", audio_valid_out); end
      n_tests++; if (active_voices_out !== '0) begin n_fail++; $display("FAIL reset_active: got %h expected 00", active_voices_out); end
      n_tests++; if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun_out); end
      n_tests++; if (lut_addr_out !== '0) begin n_fail++; $display("FAIL reset_lut_addr: got %h expected 0", lut_addr_out); end
      n_tests++; if (note_on_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", note_on_ready_out); end
   endtask

   task automatic test_single_note();
      int exp;
      do_reset();
      drive_cycle(0, 1, 7'd60, 32'h0100_0000, 0, 7'd0);
      m_note_on(7'd60, 32'h0100_0000);
      n_tests++; if (active_voices_out !== 8'h01) begin n_fail++; $display("FAIL single_active: got %h expected 01", active_voices_out); end
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0);
      m_frame(exp);
      collect_frame(0);
      n_tests++; if (f_lat !== 11) begin n_fail++; $display("FAIL single_latency: got %0d expected 11", f_lat); end
      n_tests++; if (f_pulses !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", f_pulses); end
      n_tests++; if (f_audio !== exp) begin n_fail++; $display("FAIL single_audio: got %0d expected %0d", f_audio, exp); end
      for (int c = 1; c <= 24; c++) begin
         n_tests++;
         if (obs_addr[c] !== 0) begin n_fail++; $display("FAIL single_addr_f1 c=%0d: got %h expected 0", c, obs_addr[c]); end
      end
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0);
      m_frame(exp);
      collect_frame(0);
      n_tests++; if (obs_addr[1] !== 'h010) begin n_fail++; $display("FAIL single_phase_adv: got %h expected 010", obs_addr[1]); end
      n_tests++; if (f_audio !== exp) begin n_fail++; $display("FAIL single_audio_f2: got %0d expected %0d", f_audio, exp); end
   endtask

   task automatic test_steal();
      do_reset();
      for (int id = 1; id <= 9; id++) begin
         drive_cycle(0, 1, 7'(id), 32'h0010_0000 * id, 0, 7'd0);
         m_note_on(7'(id), 32'h0010_0000 * id);
      end
      n_tests++; if (active_voices_out !== m_bitmap()) begin n_fail++; $display("FAIL steal_full: got %h expected %h", active_voices_out, m_bitmap()); end
      drive_cycle(0, 1, 7'd10, 32'h0003_0000, 0, 7'd0); m_note_on(7'd10, 32'h0003_0000);
      drive_cycle(0, 0, 7'd0, 32'd0, 1, 7'd1); m_note_off(7'd1);
      drive_cycle(0, 0, 7'd0, 32'd0, 1, 7'd2); m_note_off(7'd2);
      n_tests++; if (active_voices_out !== 8'hFF) begin n_fail++; $display("FAIL steal_evicted_ids: got %h expected ff", active_voices_out); end
      drive_cycle(0, 0, 7'd0, 32'd0, 1, 7'd9); m_note_off(7'd9);
      n_tests++; if (active_voices_out !== 8'hFE) begin n_fail++; $display("FAIL steal_first_v0: got %h expected fe", active_voices_out); end
      drive_cycle(0, 0, 7'd0, 32'd0, 1, 7'd10); m_note_off(7'd10);
      n_tests++; if (active_voices_out !== 8'hFC) begin n_fail++; $display("FAIL steal_second_v1: got %h expected fc", active_voices_out); end
      drive_cycle(0, 0, 7'd0, 32'd0, 1, 7'd3); m_note_off(7'd3);
      n_tests++; if (active_voices_out !== m_bitmap()) begin n_fail++; $display("FAIL steal_off3: got %h expected %h", active_voices_out, m_bitmap()); end
   endtask

   task automatic test_retrigger();
      int exp;
      do_reset();
      drive_cycle(0, 1, 7'd5, 32'h0123_4567, 0, 7'd0); m_note_on(7'd5, 32'h0123_4567);
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0); m_frame(exp); collect_frame(0);
      drive_cycle(0, 1, 7'd5, 32'h0200_0000, 0, 7'd0); m_note_on(7'd5, 32'h0200_0000);
      n_tests++; if (active_voices_out !== 8'h01) begin n_fail++; $display("FAIL retrig_one_bit: got %h expected 01", active_voices_out); end
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0); m_frame(exp); collect_frame(0);
      n_tests++; if (obs_addr[1] !== 0) begin n_fail++; $display("FAIL retrig_phase0: got %h expected 0", obs_addr[1]); end
      n_tests++; if (f_audio !== exp) begin n_fail++; $display("FAIL retrig_audio: got %0d expected %0d", f_audio, exp); end
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0); m_frame(exp); collect_frame(0);
      n_tests++; if (obs_addr[1] !== 'h020) begin n_fail++; $display("FAIL retrig_incr_b: got %h expected 020", obs_addr[1]); end
   endtask

   task automatic test_overrun();
      int exp;
      do_reset();
      drive_cycle(0, 1, 7'd3, 32'h0080_0000, 0, 7'd0); m_note_on(7'd3, 32'h0080_0000);
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0); m_frame(exp); collect_frame(3);
      n_tests++; if (obs_ready[3] !== 1'b0) begin n_fail++; $display("FAIL overrun_ready_sweep: got %b expected 0", obs_ready[3]); end
      n_tests++; if (f_pulses !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 1", f_pulses); end
      n_tests++; if (f_lat !== 11) begin n_fail++; $display("FAIL overrun_latency: got %0d expected 11", f_lat); end
      n_tests++; if (overrun_out !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", overrun_out); end
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0); m_frame(exp); collect_frame(0);
      n_tests++; if (f_audio !== exp) begin n_fail++; $display("FAIL overrun_next_audio: got %0d expected %0d", f_audio, exp); end
      n_tests++; if (overrun_out !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun_out); end
   endtask

   task automatic test_full_scale();
      int exp;
      lut_mode = 1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive_cycle(0, 1, 7'(20 + i), $urandom, 0, 7'd0);
      end
      for (int i = 0; i < 8; i++) m_note_on(7'(20 + i), 32'd0);
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0); m_frame(exp); collect_frame(0);
      n_tests++; if (f_audio !== 1023) begin n_fail++; $display("FAIL full_pos: got %0d expected 1023", f_audio); end
      lut_mode = 2;
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0); collect_frame(0);
      n_tests++; if (f_audio !== -1024) begin n_fail++; $display("FAIL full_neg: got %0d expected -1024", f_audio); end
      for (int i = 0; i < 8; i++) drive_cycle(0, 0, 7'd0, 32'd0, 1, 7'(20 + i));
      n_tests++; if (active_voices_out !== '0) begin n_fail++; $display("FAIL full_all_off: got %h expected 00", active_voices_out); end
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0); collect_frame(0);
      n_tests++; if (f_audio !== 0) begin n_fail++; $display("FAIL full_silent: got %0d expected 0", f_audio); end
      lut_mode = 0;
   endtask

   task automatic test_random();
      int exp, ea, op;
      logic [6:0] id, id2;
      logic [31:0] incr;
      lut_mode = 0;
      do_reset();
      for (int it = 0; it < 60; it++) begin
         op   = $urandom_range(0, 5);
         id   = 7'($urandom_range(0, 11));
         id2  = ($urandom_range(0, 1) == 0) ? id : 7'($urandom_range(0, 11));
         incr = $urandom;
         if (op <= 1) begin
            drive_cycle(0, 1, id, incr, 0, 7'd0); m_note_on(id, incr);
         end else if (op == 2) begin
            drive_cycle(0, 0, 7'd0, 32'd0, 1, id); m_note_off(id);
         end else if (op == 3) begin
            drive_cycle(0, 1, id2, incr, 1, id); m_note_off(id); m_note_on(id2, incr);
         end else begin
            if (op == 4) begin
               drive_cycle(1, 1, id, incr, 0, 7'd0); m_note_on(id, incr);
            end else begin
               drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0);
            end
            m_frame(exp);
            collect_frame(0);
            n_tests++; if (f_lat !== 11) begin n_fail++; $display("FAIL rnd_latency it=%0d: got %0d expected 11", it, f_lat); end
            n_tests++; if (f_pulses !== 1) begin n_fail++; $display("FAIL rnd_pulses it=%0d: got %0d expected 1", it, f_pulses); end
            n_tests++; if (f_audio !== exp) begin n_fail++; $display("FAIL rnd_audio it=%0d: got %0d expected %0d", it, f_audio, exp); end
            for (int c = 1; c <= 24; c++) begin
               ea = (c <= NV) ? m_addr[(c <= NV) ? c - 1 : 0] : 0;
               n_tests++;
               if (obs_addr[c] !== ea) begin n_fail++; $display("FAIL rnd_addr it=%0d c=%0d: got %h expected %h", it, c, obs_addr[c], ea); end
            end
         end
         n_tests++; if (active_voices_out !== m_bitmap()) begin n_fail++; $display("FAIL rnd_active it=%0d: got %h expected %h", it, active_voices_out, m_bitmap()); end
      end
   endtask

   task automatic test_reset_midsweep();
      int exp, pulses;
      lut_mode = 1;
      do_reset();
      drive_cycle(0, 1, 7'd7, 32'h0040_0000, 0, 7'd0); m_note_on(7'd7, 32'h0040_0000);
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0); m_frame(exp); collect_frame(0);
      n_tests++; if (f_audio !== exp) begin n_fail++; $display("FAIL midrst_pre_audio: got %0d expected %0d", f_audio, exp); end
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0);
      step(); step(); step();
      rst_in = 1'b1;
      step();
      n_tests++; if (audio_out !== 0) begin n_fail++; $display("FAIL midrst_audio: got %0d expected 0", audio_out); end
      n_tests++; if (audio_valid_out !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", audio_valid_out); end
      n_tests++; if (active_voices_out !== '0) begin n_fail++; $display("FAIL midrst_active: got %h expected 00", active_voices_out); end
      n_tests++; if (lut_addr_out !== '0) begin n_fail++; $display("FAIL midrst_lut_addr: got %h expected 0", lut_addr_out); end
      n_tests++; if (note_on_ready_out !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: got %b expected 1", note_on_ready_out); end
      rst_in = 1'b0;
      m_reset();
      pulses = 0;
      for (int c = 0; c < 24; c++) begin
         if (audio_valid_out) pulses++;
         step();
      end
      n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_pulse: got %0d expected 0", pulses); end
      drive_cycle(1, 0, 7'd0, 32'd0, 0, 7'd0); m_frame(exp); collect_frame(0);
      n_tests++; if (f_lat !== 11) begin n_fail++; $display("FAIL midrst_post_latency: got %0d expected 11", f_lat); end
      n_tests++; if (f_audio !== exp) begin n_fail++; $display("FAIL midrst_post_audio: got %0d expected %0d", f_audio, exp); end
      lut_mode = 0;
   endtask

   initial begin
      rst_in            = 1'b1;
      sample_tick_in    = 1'b0;
      note_on_valid_in  = 1'b0;
      note_id_in        = '0;
      note_incr_in      = '0;
      note_off_valid_in = 1'b0;
      note_off_id_in    = '0;
      test_reset();
      test_single_note();
      test_steal();
      test_retrigger();
      test_overrun();
      test_full_scale();
      test_random();
      test_reset_midsweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
